// File: rtl/risc16_ctrl_pkg.sv
// Shared encodings for the RISC16 control sequencer: state codes, one-hot opcode
// bit positions and the datapath select encodings.
package risc16_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int OP_LHI  = 0;
    localparam int OP_LLI  = 1;
    localparam int OP_LDRI = 2;
    localparam int OP_LDRR = 3;
    localparam int OP_STRI = 4;
    localparam int OP_STRR = 5;
    localparam int OP_ADD  = 6;
    localparam int OP_ADC  = 7;
    localparam int OP_SUB  = 8;
    localparam int OP_SBB  = 9;
    localparam int OP_CMP  = 10;
    localparam int OP_ADDI = 11;
    localparam int OP_SUBI = 12;
    localparam int OP_MOV  = 13;
    localparam int OP_BCC  = 14;
    localparam int OP_BCS  = 15;
    localparam int OP_BNE  = 16;
    localparam int OP_BEQ  = 17;
    localparam int OP_BAL  = 18;
    localparam int OP_JMP  = 19;
    localparam int OP_JALL = 20;
    localparam int OP_JALR = 21;
    localparam int OP_JR   = 22;
    localparam int OP_OUTR = 23;
    localparam int OP_HLT  = 24;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_ADC   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_SBB   = 3'd3;
    localparam logic [2:0] ALU_PASSB = 3'd4;
    localparam logic [2:0] ALU_LHI   = 3'd5;
    localparam logic [2:0] ALU_LLI   = 3'd6;

    localparam logic [1:0] PC_SEL_DISP = 2'd0;
    localparam logic [1:0] PC_SEL_ABS  = 2'd1;
    localparam logic [1:0] PC_SEL_REG  = 2'd2;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_LINK = 2'd2;

endpackage

// File: rtl/branch_cond16.sv
// Conditional-branch resolver: takes the five branch opcode bits (BCC, BCS, BNE,
// BEQ, BAL in that order) and the ALU flags, and says whether the branch is taken.
module branch_cond16 (
    input  logic [4:0] OP_BR,
    input  logic       FLAG_C,
    input  logic       FLAG_Z,
    output logic       TAKE
);

    assign TAKE = (OP_BR[0] & ~FLAG_C) |
                  (OP_BR[1] &  FLAG_C) |
                  (OP_BR[2] & ~FLAG_Z) |
                  (OP_BR[3] &  FLAG_Z) |
                   OP_BR[4];

endmodule

// File: rtl/ctrl_seq16.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit RISC core.
// Build option ILLEGAL_TRAP_EN: an illegal opcode halts the core instead of acting as a NOP.
module ctrl_seq16 #(
    parameter int OP_W = 25,
    parameter int ST_W = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RUN,
    input  logic [OP_W-1:0] OP,
    input  logic            FLAG_C,
    input  logic            FLAG_Z,
    input  logic            MEM_ACK,
    output logic [ST_W-1:0] STATE,
    output logic            IR_LD,
    output logic            PC_INC,
    output logic            PC_LD,
    output logic [1:0]      PC_SEL,
    output logic            ADDR_SEL,
    output logic            MEM_REQ,
    output logic            MEM_WE,
    output logic            RF_WE,
    output logic [1:0]      RF_WSEL,
    output logic [2:0]      ALU_OP,
    output logic            ALU_SRC_IMM,
    output logic            FLAGS_LD,
    output logic            OUT_LD,
    output logic            HALTED,
    output logic            ILL
);
    import risc16_ctrl_pkg::*;

    state_t state;
    logic   legal;
    logic   is_store;
    logic   is_mem;
    logic   take;

    assign legal    = (OP != '0) && ((OP & (OP - OP_W'(1))) == '0);
    assign is_store = OP[OP_STRI] | OP[OP_STRR];
    assign is_mem   = OP[OP_LDRI] | OP[OP_LDRR] | is_store;

    branch_cond16 u_branch (
        .OP_BR (OP[OP_BAL:OP_BCC]),
        .FLAG_C(FLAG_C),
        .FLAG_Z(FLAG_Z),
        .TAKE  (take)
    );

    assign STATE = ST_W'(state);

    // The instruction register loads with the fetched word in the cycle memory acknowledges it.
    assign IR_LD  = (state == S_FETCH) && MEM_ACK;
    assign PC_INC = (state == S_FETCH) && MEM_ACK;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            PC_LD       <= 1'b0;
            PC_SEL      <= PC_SEL_DISP;
            ADDR_SEL    <= 1'b0;
            MEM_REQ     <= 1'b0;
            MEM_WE      <= 1'b0;
            RF_WE       <= 1'b0;
            RF_WSEL     <= WSEL_ALU;
            ALU_OP      <= ALU_ADD;
            ALU_SRC_IMM <= 1'b0;
            FLAGS_LD    <= 1'b0;
            OUT_LD      <= 1'b0;
            HALTED      <= 1'b0;
            ILL         <= 1'b0;
        end else begin
            PC_LD       <= 1'b0;
            PC_SEL      <= PC_SEL_DISP;
            ADDR_SEL    <= 1'b0;
            MEM_REQ     <= 1'b0;
            MEM_WE      <= 1'b0;
            RF_WE       <= 1'b0;
            RF_WSEL     <= WSEL_ALU;
            ALU_OP      <= ALU_ADD;
            ALU_SRC_IMM <= 1'b0;
            FLAGS_LD    <= 1'b0;
            OUT_LD      <= 1'b0;
            HALTED      <= 1'b0;
            ILL         <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (RUN) begin
                        state   <= S_FETCH;
                        MEM_REQ <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (MEM_ACK) begin
                        state <= S_DECODE;
                    end else begin
                        MEM_REQ <= 1'b1;
                    end
                end

                // Strobes registered here are the ones presented during EXEC.
                S_DECODE: begin
                    state <= S_EXEC;
                    if (!legal) begin
                        ILL <= 1'b1;
                    end else begin
                        case (1'b1)
                            OP[OP_ADD]:  begin RF_WE <= 1'b1; FLAGS_LD <= 1'b1; ALU_OP <= ALU_ADD; end
                            OP[OP_ADC]:  begin RF_WE <= 1'b1; FLAGS_LD <= 1'b1; ALU_OP <= ALU_ADC; end
                            OP[OP_SUB]:  begin RF_WE <= 1'b1; FLAGS_LD <= 1'b1; ALU_OP <= ALU_SUB; end
                            OP[OP_SBB]:  begin RF_WE <= 1'b1; FLAGS_LD <= 1'b1; ALU_OP <= ALU_SBB; end
                            OP[OP_ADDI]: begin
                                RF_WE <= 1'b1; FLAGS_LD <= 1'b1; ALU_OP <= ALU_ADD; ALU_SRC_IMM <= 1'b1;
                            end
                            OP[OP_SUBI]: begin
                                RF_WE <= 1'b1; FLAGS_LD <= 1'b1; ALU_OP <= ALU_SUB; ALU_SRC_IMM <= 1'b1;
                            end
                            OP[OP_CMP]:  begin FLAGS_LD <= 1'b1; ALU_OP <= ALU_SUB; end
                            OP[OP_MOV]:  begin RF_WE <= 1'b1; ALU_OP <= ALU_PASSB; end
                            OP[OP_LHI]:  begin RF_WE <= 1'b1; ALU_OP <= ALU_LHI; end
                            OP[OP_LLI]:  begin RF_WE <= 1'b1; ALU_OP <= ALU_LLI; end
                            OP[OP_LDRI], OP[OP_STRI]: begin ALU_OP <= ALU_ADD; ALU_SRC_IMM <= 1'b1; end
                            OP[OP_LDRR], OP[OP_STRR]: ALU_OP <= ALU_ADD;
                            OP[OP_BCC], OP[OP_BCS], OP[OP_BNE], OP[OP_BEQ], OP[OP_BAL]: begin
                                PC_LD  <= take;
                                PC_SEL <= PC_SEL_DISP;
                            end
                            OP[OP_JMP]:  begin PC_LD <= 1'b1; PC_SEL <= PC_SEL_ABS; end
                            OP[OP_JALL]: begin
                                RF_WE <= 1'b1; RF_WSEL <= WSEL_LINK; PC_LD <= 1'b1; PC_SEL <= PC_SEL_DISP;
                            end
                            OP[OP_JALR]: begin
                                RF_WE <= 1'b1; RF_WSEL <= WSEL_LINK; PC_LD <= 1'b1; PC_SEL <= PC_SEL_REG;
                            end
                            OP[OP_JR]:   begin PC_LD <= 1'b1; PC_SEL <= PC_SEL_REG; end
                            OP[OP_OUTR]: OUT_LD <= 1'b1;
                            default: ;
                        endcase
                    end
                end

                S_EXEC: begin
                    if (legal && is_mem) begin
                        state       <= S_MEM;
                        MEM_REQ     <= 1'b1;
                        ADDR_SEL    <= 1'b1;
                        MEM_WE      <= is_store;
                        ALU_OP      <= ALU_OP;
                        ALU_SRC_IMM <= ALU_SRC_IMM;
                    end else if (legal && OP[OP_HLT]) begin
                        state  <= S_HALT;
                        HALTED <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    end else if (!legal) begin
                        state  <= S_HALT;
                        HALTED <= 1'b1;
                        ILL    <= 1'b1;
`endif
                    end else begin
                        state   <= S_FETCH;
                        MEM_REQ <= 1'b1;
                    end
                end

                // The address computation stays on the ALU until memory completes.
                S_MEM: begin
                    if (MEM_ACK) begin
                        if (MEM_WE) begin
                            state   <= S_FETCH;
                            MEM_REQ <= 1'b1;
                        end else begin
                            state   <= S_WB;
                            RF_WE   <= 1'b1;
                            RF_WSEL <= WSEL_MEM;
                        end
                    end else begin
                        MEM_REQ     <= 1'b1;
                        ADDR_SEL    <= 1'b1;
                        MEM_WE      <= MEM_WE;
                        ALU_OP      <= ALU_OP;
                        ALU_SRC_IMM <= ALU_SRC_IMM;
                    end
                end

                S_WB: begin
                    state   <= S_FETCH;
                    MEM_REQ <= 1'b1;
                end

                S_HALT: begin
                    HALTED <= 1'b1;
                    ILL    <= ILL;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq16.sv
// Scoreboard bench for ctrl_seq16: a cycle-level plan of inputs and expected outputs is
// built from the instruction rules, a driver plays it and a monitor checks every cycle.
module tb_ctrl_seq16;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RUN = 1'b0;
    logic [24:0] OP = '0;
    logic        FLAG_C = 1'b0;
    logic        FLAG_Z = 1'b0;
    logic        MEM_ACK = 1'b0;
    logic [2:0]  STATE;
    logic        IR_LD, PC_INC, PC_LD;
    logic [1:0]  PC_SEL;
    logic        ADDR_SEL, MEM_REQ, MEM_WE, RF_WE;
    logic [1:0]  RF_WSEL;
    logic [2:0]  ALU_OP;
    logic        ALU_SRC_IMM, FLAGS_LD, OUT_LD, HALTED, ILL;

    ctrl_seq16 dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .OP(OP), .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z),
        .MEM_ACK(MEM_ACK), .STATE(STATE), .IR_LD(IR_LD), .PC_INC(PC_INC), .PC_LD(PC_LD),
        .PC_SEL(PC_SEL), .ADDR_SEL(ADDR_SEL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .RF_WE(RF_WE), .RF_WSEL(RF_WSEL), .ALU_OP(ALU_OP), .ALU_SRC_IMM(ALU_SRC_IMM),
        .FLAGS_LD(FLAGS_LD), .OUT_LD(OUT_LD), .HALTED(HALTED), .ILL(ILL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_ld;
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       mem_req;
        logic       mem_we;
        logic       rf_we;
        logic [1:0] rf_wsel;
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       flags_ld;
        logic       out_ld;
        logic       halted;
        logic       ill;
    } snap_t;

    typedef struct {
        bit          ack;
        bit          rst;
        bit          run;
        logic [24:0] op;
        bit          fc;
        bit          fz;
        snap_t       exp;
    } stim_t;

    stim_t       stim_q[$];
    snap_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [24:0] cur_op = '0;
    bit          cur_fc = 1'b0;
    bit          cur_fz = 1'b0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic snap_t mk(input int st);
        snap_t s;
        s = '0;
        s.st = 3'(st);
        return s;
    endfunction

    function automatic string stName(input logic [2:0] st);
        case (st)
            3'd0: return "IDLE";
            3'd1: return "FETCH";
            3'd2: return "DECODE";
            3'd3: return "EXEC";
            3'd4: return "MEM";
            3'd5: return "WB";
            3'd6: return "HALT";
            default: return "BAD";
        endcase
    endfunction

    // Expected EXEC-cycle strobes, written straight from the instruction table.
    function automatic snap_t execSnap(input int opSel, input bit fc, input bit fz);
        snap_t s;
        s = mk(3);
        case (opSel)
            0:  begin s.rf_we = 1; s.alu_op = 5; end
            1:  begin s.rf_we = 1; s.alu_op = 6; end
            2, 4: begin s.alu_op = 0; s.alu_src_imm = 1; end
            3, 5: s.alu_op = 0;
            6:  begin s.rf_we = 1; s.flags_ld = 1; s.alu_op = 0; end
            7:  begin s.rf_we = 1; s.flags_ld = 1; s.alu_op = 1; end
            8:  begin s.rf_we = 1; s.flags_ld = 1; s.alu_op = 2; end
            9:  begin s.rf_we = 1; s.flags_ld = 1; s.alu_op = 3; end
            10: begin s.flags_ld = 1; s.alu_op = 2; end
            11: begin s.rf_we = 1; s.flags_ld = 1; s.alu_op = 0; s.alu_src_imm = 1; end
            12: begin s.rf_we = 1; s.flags_ld = 1; s.alu_op = 2; s.alu_src_imm = 1; end
            13: begin s.rf_we = 1; s.alu_op = 4; end
            14: s.pc_ld = !fc;
            15: s.pc_ld = fc;
            16: s.pc_ld = !fz;
            17: s.pc_ld = fz;
            18: s.pc_ld = 1;
            19: begin s.pc_ld = 1; s.pc_sel = 1; end
            20: begin s.rf_we = 1; s.rf_wsel = 2; s.pc_ld = 1; s.pc_sel = 0; end
            21: begin s.rf_we = 1; s.rf_wsel = 2; s.pc_ld = 1; s.pc_sel = 2; end
            22: begin s.pc_ld = 1; s.pc_sel = 2; end
            23: s.out_ld = 1;
            24: ;
            default: s.ill = 1;
        endcase
        return s;
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s.st = STATE; s.ir_ld = IR_LD; s.pc_inc = PC_INC; s.pc_ld = PC_LD;
        s.pc_sel = PC_SEL; s.addr_sel = ADDR_SEL; s.mem_req = MEM_REQ; s.mem_we = MEM_WE;
        s.rf_we = RF_WE; s.rf_wsel = RF_WSEL; s.alu_op = ALU_OP; s.alu_src_imm = ALU_SRC_IMM;
        s.flags_ld = FLAGS_LD; s.out_ld = OUT_LD; s.halted = HALTED; s.ill = ILL;
        return s;
    endfunction

    task automatic push(input bit ack, input bit rst, input bit run, input snap_t e);
        stim_t t;
        t.ack = ack; t.rst = rst; t.run = run;
        t.op = cur_op; t.fc = cur_fc; t.fz = cur_fz;
        t.exp = e;
        stim_q.push_back(t);
    endtask

    // opSel 0..24 selects one opcode bit; 25 is an all-zero OP, 26 sets two bits.
    task automatic applyStimulus(input int opSel, input bit fc, input bit fz,
                                 input int fd, input int md, output bit halted);
        logic [24:0] v;
        snap_t       s;
        bit          legal;
        int          a;
        int          b;
        v = '0;
        if (opSel < 25) begin
            v[opSel] = 1'b1;
        end else if (opSel == 26) begin
            a = $urandom_range(0, 24);
            b = (a + 1 + $urandom_range(0, 23)) % 25;
            v[a] = 1'b1;
            v[b] = 1'b1;
        end
        cur_op = v; cur_fc = fc; cur_fz = fz;
        legal = (opSel < 25);

        for (int i = 0; i < fd; i++) begin
            s = mk(1); s.mem_req = 1;
            push(1'b0, 1'b0, rb(), s);
        end
        s = mk(1); s.mem_req = 1; s.ir_ld = 1; s.pc_inc = 1;
        push(1'b1, 1'b0, rb(), s);
        push(rb(), 1'b0, rb(), mk(2));
        push(rb(), 1'b0, rb(), execSnap(opSel, fc, fz));

        if (legal && opSel >= 2 && opSel <= 5) begin
            s = mk(4); s.mem_req = 1; s.addr_sel = 1;
            s.mem_we = (opSel >= 4);
            s.alu_op = 0;
            s.alu_src_imm = (opSel == 2 || opSel == 4);
            for (int i = 0; i < md; i++) push(1'b0, 1'b0, rb(), s);
            push(1'b1, 1'b0, rb(), s);
            if (opSel <= 3) begin
                s = mk(5); s.rf_we = 1; s.rf_wsel = 1;
                push(rb(), 1'b0, rb(), s);
            end
        end
        halted = (opSel == 24) || (!legal && TRAP);
    endtask

    task automatic haltAndReset(input bit ill, input int n);
        snap_t s;
        s = mk(6); s.halted = 1; s.ill = ill;
        for (int i = 0; i < n; i++) push(rb(), 1'b0, 1'(i % 2), s);
        push(rb(), 1'b1, rb(), s);
        push(rb(), 1'b0, 1'b0, mk(0));
        push(rb(), 1'b0, 1'b1, mk(0));
    endtask

    // Load that is abandoned by a reset while memory is still stalled.
    task automatic abortInMem();
        snap_t s;
        cur_op = 25'd1 << 2; cur_fc = 1'b0; cur_fz = 1'b0;
        s = mk(1); s.mem_req = 1; s.ir_ld = 1; s.pc_inc = 1;
        push(1'b1, 1'b0, 1'b0, s);
        push(1'b0, 1'b0, 1'b0, mk(2));
        push(1'b0, 1'b0, 1'b0, execSnap(2, 1'b0, 1'b0));
        s = mk(4); s.mem_req = 1; s.addr_sel = 1; s.alu_src_imm = 1;
        push(1'b0, 1'b0, 1'b0, s);
        push(1'b0, 1'b1, 1'b0, s);
        push(1'b1, 1'b0, 1'b0, mk(0));
        push(1'b1, 1'b0, 1'b0, mk(0));
    endtask

    task automatic checkOutput(input snap_t e);
        snap_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL %s cycle @%0t: got st=%0d bits=%h, expected st=%0d bits=%h",
                     stName(e.st), $time, a.st, a, e.st, e);
        end
    endtask

    initial begin : driver
        stim_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (stim_q.size() != 0) begin
                e = stim_q.pop_front();
                RST = e.rst; RUN = e.run; MEM_ACK = e.ack;
                OP = e.op; FLAG_C = e.fc; FLAG_Z = e.fz;
                exp_q.push_back(e.exp);
            end else begin
                RST = 1'b0; RUN = 1'b0; MEM_ACK = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end

    initial begin : main
        bit h;
        int sel;
        int n;

        push(1'b0, 1'b1, 1'b0, mk(0));
        push(1'b1, 1'b0, 1'b0, mk(0));
        push(1'b0, 1'b0, 1'b1, mk(0));

        applyStimulus(6, 1'b0, 1'b0, 0, 0, h);
        applyStimulus(3, 1'b0, 1'b0, 0, 2, h);
        applyStimulus(17, 1'b0, 1'b1, 0, 0, h);
        applyStimulus(17, 1'b0, 1'b0, 0, 0, h);
        applyStimulus(14, 1'b0, 1'b1, 1, 0, h);
        applyStimulus(21, 1'b1, 1'b0, 0, 0, h);
        applyStimulus(4, 1'b0, 1'b0, 1, 1, h);
        applyStimulus(25, 1'b0, 1'b0, 0, 0, h);
        if (h) haltAndReset(1'b1, 3);
        applyStimulus(26, 1'b1, 1'b1, 0, 0, h);
        if (h) haltAndReset(1'b1, 3);

        for (int i = 0; i < 60; i++) begin
            do sel = $urandom_range(0, 26);
            while (sel == 24 || (TRAP && sel >= 25));
            applyStimulus(sel, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2), h);
        end

        applyStimulus(24, 1'b0, 1'b0, 0, 0, h);
        haltAndReset(1'b0, 10);
        applyStimulus(23, 1'b0, 1'b0, 0, 0, h);
        abortInMem();

        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        if (stim_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d stimulus and %0d expected entries left, required 0",
                     stim_q.size(), exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
